// File: rtl/audio_pkg.sv
// Shared widths, defaults and the per-voice level helper for the square-voice mixer.
// Pure declarations: no latency, no flow control.
package audio_pkg;

    localparam int NUM_VOICES       = 4;
    localparam int FREQ_W           = 8;
    localparam int MIX_W            = 10;
    localparam int PWM_W            = 10;
    localparam int AMP_DEFAULT      = 255;
    localparam int PRESCALE_DEFAULT = 1024;

    // Contribution of one voice to the mix; 4 * 255 = 1020 always fits in MIX_W.
    function automatic logic [MIX_W-1:0] voice_level(input logic on, input logic [7:0] amp);
        return on ? MIX_W'(amp) : '0;
    endfunction

endpackage

// File: rtl/square_voice_mixer_if.sv
// Half-period inputs and audio outputs of the square-voice mixer.
// Quasi-static controls, no handshake and no backpressure.
interface square_voice_mixer_if;
    import audio_pkg::*;

    logic [FREQ_W-1:0]     freq1;
    logic [FREQ_W-1:0]     freq2;
    logic [FREQ_W-1:0]     freq3;
    logic [FREQ_W-1:0]     freq4;
    logic                  tick;
    logic [NUM_VOICES-1:0] voice_sq;
    logic [NUM_VOICES-1:0] voice_active;
    logic [MIX_W-1:0]      mix_sample;
    logic                  audio_out;

    modport master (
        output freq1, freq2, freq3, freq4,
        input  tick, voice_sq, voice_active, mix_sample, audio_out
    );

    modport slave (
        input  freq1, freq2, freq3, freq4,
        output tick, voice_sq, voice_active, mix_sample, audio_out
    );

endinterface

// File: rtl/square_voice.sv
// One square-wave voice: toggles every freq ticks, forced low while freq is 0.
// Latency: sq/active registered 1 clk after the tick/freq sample; no backpressure.
module square_voice
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [FREQ_W-1:0] freq,
    output logic              sq,
    output logic              active
);

    logic [FREQ_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= '0;
            sq     <= 1'b0;
            active <= 1'b0;
        end else begin
            active <= (freq != '0);
            if (tick) begin
                if (freq == '0) begin
                    phase <= '0;
                    sq    <= 1'b0;
                // ">=" so a lowered freq mid-half-period toggles at once instead of wrapping
                end else if (phase >= freq - FREQ_W'(1)) begin
                    phase <= '0;
                    sq    <= ~sq;
                end else begin
                    phase <= phase + FREQ_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/square_voice_mixer.sv
// Four square voices summed into a 10-bit level and rendered as 1-bit PWM.
// Latency: mix 1 clk after voice_sq, PWM level taken at frame wrap; no backpressure.
module square_voice_mixer
    import audio_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT,
    parameter int AMP      = AMP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    square_voice_mixer_if.slave  bus
);

    localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [7:0]        AMP_LVL  = 8'(AMP);
    localparam logic [PWM_W-1:0]  PWM_LAST = '1;

    logic [PRE_W-1:0]      pre_cnt;
    logic                  tick;
    logic [FREQ_W-1:0]     freq [NUM_VOICES];
    logic [NUM_VOICES-1:0] sq;
    logic [NUM_VOICES-1:0] active;
    logic [MIX_W-1:0]      mix_next;
    logic [MIX_W-1:0]      mix_sample;
    logic [PWM_W-1:0]      pwm_cnt;
    logic [MIX_W-1:0]      pwm_lvl;
    logic                  audio_q;

    // Gated by reset so a PRESCALE of 1 still shows a quiet tick while held in reset.
    assign tick = ~reset & (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign freq[0] = bus.freq1;
    assign freq[1] = bus.freq2;
    assign freq[2] = bus.freq3;
    assign freq[3] = bus.freq4;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        square_voice u_voice (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .freq   (freq[v]),
            .sq     (sq[v]),
            .active (active[v])
        );
    end

    always_comb begin
        mix_next = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_next = mix_next + voice_level(sq[v], AMP_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mix_sample <= '0;
        end else begin
            mix_sample <= mix_next;
        end
    end

    // Level only changes at the frame wrap so each PWM frame has a single duty.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm_lvl <= '0;
            audio_q <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            audio_q <= (pwm_cnt < pwm_lvl);
            if (pwm_cnt == PWM_LAST) begin
                pwm_lvl <= mix_sample;
            end
        end
    end

    assign bus.tick         = tick;
    assign bus.voice_sq     = sq;
    assign bus.voice_active = active;
    assign bus.mix_sample   = mix_sample;
    assign bus.audio_out    = audio_q;

endmodule

// File: tb/tb_square_voice_mixer.sv
// Bench for square_voice_mixer: lane 0 at PRESCALE=2, lane 1 at PRESCALE=1, both AMP=255.
// A cycle-count based model is compared every cycle, plus hand-computed directed checks.
module tb_square_voice_mixer;
    import audio_pkg::*;

    localparam int AMPV = 255;

    logic       clk = 1'b0;
    logic       rst [2];
    logic [7:0] frq [2][4];
    logic       tick_o [2];
    logic [3:0] vsq_o  [2];
    logic [3:0] vact_o [2];
    logic [9:0] mix_o  [2];
    logic       aud_o  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int P = (g == 0) ? 2 : 1;

        square_voice_mixer_if bus ();

        assign bus.freq1 = frq[g][0];
        assign bus.freq2 = frq[g][1];
        assign bus.freq3 = frq[g][2];
        assign bus.freq4 = frq[g][3];

        square_voice_mixer #(.PRESCALE(P), .AMP(AMPV)) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus.slave)
        );

        assign tick_o[g] = bus.tick;
        assign vsq_o[g]  = bus.voice_sq;
        assign vact_o[g] = bus.voice_active;
        assign mix_o[g]  = bus.mix_sample;
        assign aud_o[g]  = bus.audio_out;

        // Model state: n = clocks since reset released; frame position is n mod 1024.
        int n;
        int ph  [4];
        bit sq  [4];
        bit act [4];
        int mix;
        int lvl;
        bit aud;
        bit started = 1'b0;
        int hi;
        int pos;
        int f;
        bit tk;

        initial forever begin
            @(posedge clk);
            started = 1'b1;
            if (rst[g]) begin
                n = 0; mix = 0; lvl = 0; aud = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    ph[i] = 0; sq[i] = 1'b0; act[i] = 1'b0;
                end
            end else begin
                pos = n % 1024;
                tk  = (n % P) == (P - 1);
                hi  = 0;
                for (int i = 0; i < 4; i++) if (sq[i]) hi++;
                aud = pos < lvl;
                if (pos == 1023) lvl = mix;
                mix = hi * AMPV;
                if (tk) begin
                    for (int i = 0; i < 4; i++) begin
                        f = int'(frq[g][i]);
                        if (f == 0) begin
                            ph[i] = 0; sq[i] = 1'b0;
                        end else if (ph[i] >= f - 1) begin
                            ph[i] = 0; sq[i] = !sq[i];
                        end else begin
                            ph[i] = ph[i] + 1;
                        end
                    end
                end
                for (int i = 0; i < 4; i++) act[i] = (frq[g][i] != 8'd0);
                n++;
            end
        end

        initial forever begin
            int exp_v;
            int got_v;
            int sqb;
            int actb;
            @(negedge clk);
            if (started) begin
                sqb = 0; actb = 0;
                for (int i = 0; i < 4; i++) begin
                    if (sq[i])  sqb  = sqb  + (1 << i);
                    if (act[i]) actb = actb + (1 << i);
                end
                exp_v = ((!rst[g] && ((n % P) == (P - 1))) ? (1 << 19) : 0)
                      | (sqb << 15) | (actb << 11) | (mix << 1) | (aud ? 1 : 0);
                got_v = (int'(tick_o[g]) << 19) | (int'(vsq_o[g]) << 15)
                      | (int'(vact_o[g]) << 11) | (int'(mix_o[g]) << 1) | int'(aud_o[g]);
                chk($sformatf("lane%0d_model_n%0d", g, n), got_v, exp_v);
            end
        end
    end

    task automatic go(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic reset0;
        rst[0] = 1'b1;
        go(3);
        rst[0] = 1'b0;
    endtask

    task automatic lane0_seq;
        int c;
        int hi;
        // Reset held with freq1=5, then first rise 5 ticks = 10 clks later.
        frq[0][0] = 8'd5;
        go(1);
        chk("reset_hold_outputs", int'({vsq_o[0], vact_o[0], mix_o[0], aud_o[0], tick_o[0]}), 0);
        go(2);
        rst[0] = 1'b0;
        c = 0;
        for (int k = 1; k <= 40; k++) begin
            go(1);
            if (vsq_o[0][0]) begin
                c = k;
                break;
            end
        end
        chk("first_rise_clks", c, 10);
        chk("active_f5", int'(vact_o[0]), 1);

        // Steady tone freq1=3: toggles at e6, e12; mix follows one clk later.
        frq[0][0] = 8'd3;
        reset0();
        go(6);
        chk("steady_rise_sq", int'(vsq_o[0]), 1);
        chk("steady_rise_mix_lag", int'(mix_o[0]), 0);
        go(1);
        chk("steady_mix_high", int'(mix_o[0]), 255);
        go(5);
        chk("steady_fall_sq", int'(vsq_o[0]), 0);
        go(1);
        chk("steady_mix_low", int'(mix_o[0]), 0);
        chk("steady_active", int'(vact_o[0]), 1);

        // Down-change at phase 50: 200 -> 10 toggles on the next tick.
        frq[0][0] = 8'd200;
        reset0();
        go(100);
        frq[0][0] = 8'd10;
        go(1);
        chk("down_before_tick", int'(vsq_o[0][0]), 0);
        go(1);
        chk("down_next_tick", int'(vsq_o[0][0]), 1);
        go(19);
        chk("down_half_hold", int'(vsq_o[0][0]), 1);
        go(1);
        chk("down_half_10", int'(vsq_o[0][0]), 0);
        go(20);
        chk("down_half_10b", int'(vsq_o[0][0]), 1);

        // Silence mid-note on voice 2, then re-enable.
        frq[0][0] = 8'd0;
        frq[0][1] = 8'd4;
        reset0();
        go(9);
        chk("silence_pre_high", int'(vsq_o[0][1]), 1);
        frq[0][1] = 8'd0;
        go(1);
        chk("silence_forced_low", int'(vsq_o[0][1]), 0);
        chk("silence_inactive", int'(vact_o[0][1]), 0);
        go(1);
        frq[0][1] = 8'd4;
        go(6);
        chk("reenable_still_low", int'(vsq_o[0][1]), 0);
        go(1);
        chk("reenable_rise", int'(vsq_o[0][1]), 1);

        // Full mix with all voices at 1, then PWM frames at 1020 and 0.
        for (int i = 0; i < 4; i++) frq[0][i] = 8'd1;
        reset0();
        go(3);
        chk("full_mix_1020", int'(mix_o[0]), 1020);
        go(2);
        chk("full_mix_0", int'(mix_o[0]), 0);
        go(1019);
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            go(1);
            if (aud_o[0]) hi++;
        end
        chk("pwm_frame_1020", hi, 1020);
        for (int i = 0; i < 4; i++) frq[0][i] = 8'd0;
        go(1024);
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            go(1);
            if (aud_o[0]) hi++;
        end
        chk("pwm_frame_0", hi, 0);
    endtask

    task automatic lane1_seq;
        int t;
        frq[1][0] = 8'd2;
        frq[1][1] = 8'd2;
        go(2);
        rst[1] = 1'b0;
        t = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tick_o[1]) t++;
        end
        chk("p1_tick_continuous", t, 50);
        go(1);
        go(1174);
        chk("p1_audio_mid_frame", int'(aud_o[1]), 1);
        rst[1] = 1'b1;
        go(1);
        chk("p1_reset_audio", int'(aud_o[1]), 0);
        chk("p1_reset_pwm_cnt", int'(lane[1].dut.pwm_cnt), 0);
        chk("p1_reset_outputs", int'({vsq_o[1], vact_o[1], mix_o[1], tick_o[1]}), 0);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("p1_tick_after_reset", int'(tick_o[1]), 1);
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 4; i++) frq[g][i] = 8'd0;
        fork
            lane0_seq();
            lane1_seq();
        join
        go(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/square_voice_mixer.md
Name: square_voice_mixer

Overview:
- Four-voice square-wave tone generator and mixer, directly downstream of the switch/song control block.
- Consumes its four 8-bit half-period words: half a period, counted in prescaled ticks; 0 means silent.
- Toggles one square wave per voice, sums the voices into a 10-bit level, and drives a 1-bit PWM pin for the speaker/amp.

Parameters:
- PRESCALE, 1024: clk cycles per voice tick; sets the audio pitch range. Legal range is ≥1.
- AMP, 255: per-voice amplitude added to the mix when that voice's square is high. 8 bits, ≤255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- freq1  in  8  voice 1 half-period in ticks; 0 = silent
- freq2  in  8  voice 2 half-period
- freq3  in  8  voice 3 half-period
- freq4  in  8  voice 4 half-period
- tick  out  1  one-clk pulse at each prescaler wrap
- voice_sq  out  4  per-voice square level; bit0 = voice 1
- voice_active  out  4  registered (freqN != 0)
- mix_sample  out  10  registered sum of active-high voices
- audio_out  out  1  PWM of mix_sample

Behaviour:
- Reset is sampled only on a clk edge. The following are all 0 after reset:
  - prescaler count
  - every phase counter
  - voice_sq, voice_active
  - mix_sample, the PWM counter, the latched PWM level
  - tick, audio_out
- Reset asserted mid-note: every output is 0 on the next edge, with no partial toggle.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 for exactly the one clk in which pre_cnt==PRESCALE-1.
  - PRESCALE=1 gives tick high every cycle.
- Per voice, evaluated only on tick cycles (f = freqN sampled that cycle):
  - f==0: phase:=0 and sq:=0 (silence forces the line low).
  - f!=0 and phase ≥ f-1: phase:=0 and sq toggles.
  - Otherwise phase:=phase+1.
  - Period is 2·f ticks. f=1 toggles every tick. f=255 gives a 510-tick period.
  - The "≥" compare means a downward freq change mid-half-period toggles on the next tick; it never runs a 256-tick wrap.
  - An upward change extends the current half-period.
  - 0→nonzero: sq stays 0 until the first toggle, f ticks later (phase counts from 0).
- voice_active updates every clk: one-cycle register of freqN!=0.
- Mixer:
  - Every clk, mix_sample := Σ(voice_sq[i] ? AMP : 0), zero-extended to 10 bits.
  - Max is 4·255 = 1020, so there is no overflow or saturation logic.
  - Latency: 1 clk after a voice_sq change.
- PWM:
  - pwm_cnt is a free-running 10-bit counter, 0..1023, wrapping.
  - When pwm_cnt==1023, pwm_lvl := mix_sample. The level is only latched at the wrap, so the duty is glitch-free within a frame.
  - audio_out := (pwm_cnt < pwm_lvl), registered.
  - pwm_lvl=0 gives constantly 0; 1020 gives 1020 of 1024 cycles high.
- Simultaneous events:
  - Multiple voices may toggle on the same tick; the mix reflects all of them together the next clk.
  - A tick coinciding with the PWM wrap latches the pre-toggle mix_sample. This is acceptable; the new level is picked up next frame.
- No handshake. Inputs are treated as quasi-static and are synchronous to clk.

Decomposition:
- Package audio_pkg holds:
  - NUM_VOICES=4, FREQ_W=8, MIX_W=10, PWM_W=10
  - the AMP default
- One sub-module, square_voice:
  - Ports: clk, reset, tick, freq[7:0] → sq, active.
  - Instantiated four times.
- Prescaler, mixer and PWM stay in the top.

Test Plan (PRESCALE=2, AMP=255 unless noted):
- Reset: hold reset 3 clks with freq1=5 → all outputs 0 throughout; first voice_sq[0] rise exactly 5 ticks (10 clks) after reset release.
- Steady tone: freq1=3, others 0 → voice_sq[0] toggles every 3 ticks (6-tick period); mix_sample alternates 0/255 one clk after each toggle; voice_active=4'b0001.
- Down-change: freq1=200, at phase 50 set freq1=10 → toggle on the very next tick, then 10-tick half-periods; no 256-tick stall.
- Silence mid-note: freq2=4 while sq high, then freq2=0 → voice_sq[1]=0 at the next tick; phase restarts; re-enable with 4 gives the first rise 4 ticks later.
- Full mix: freq1..4 all =1 (in phase after reset) → mix_sample=1020 on every other tick. Over one aligned PWM frame with pwm_lvl=1020, audio_out is high for exactly 1020 of 1024 clks; with pwm_lvl=0, 0 clks.
- PRESCALE=1 and reset mid-PWM frame: tick stays high continuously; asserting reset mid-frame drops audio_out to 0 on the next edge, and pwm_cnt restarts at 0.
